// File: rtl/cnn_shift_pkg.sv
// Shared constants and FSM state type for the runtime-programmable
// requantization shift table.
package cnn_shift_pkg;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } state_t;

endpackage

// File: rtl/shift_table_ram.sv
// Simple dual-port shift table storage: synchronous write, registered
// read-before-write read port; contents are never reset.
module shift_table_ram
  import cnn_shift_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset so the array maps onto distributed or block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/shift_table_loader.sv
// Streams a per-channel shift table from the SoC into RAM and serves it to
// the datapath. Define SHIFT_TABLE_CHECKSUM_EN to enable the byte checksum.
module shift_table_loader
  import cnn_shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              table_valid,
  output logic [CSUM_W-1:0] checksum
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ok_q;
  logic              table_valid_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] ram_q;
  logic              hs;
  logic              at_end;

  assign hs          = s_valid & s_ready;
  assign at_end      = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign table_valid = table_valid_q;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (hs && (s_last || at_end)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = ok_q;
        err       = ~ok_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pointer saturates at the last entry so an unterminated stream never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      ok_q          <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        wr_ptr        <= '0;
        ok_q          <= 1'b0;
        table_valid_q <= 1'b0;
      end else if (state == LOAD && hs) begin
        if (!at_end) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        ok_q <= s_last & at_end;
        if (s_last && at_end) begin
          table_valid_q <= 1'b1;
        end
      end
    end
  end

  shift_table_ram u_ram (
    .clk   (clk),
    .we    (hs),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Validity is sampled alongside the address so the mask lines up with the RAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= table_valid_q;
    end
  end

  assign rd_data = rd_valid_q ? ram_q : '0;

`ifdef SHIFT_TABLE_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state == IDLE && start) begin
      csum_q <= '0;
    end else if (hs) begin
      csum_q <= csum_q + CSUM_W'(s_data);
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_shift_table_loader.sv
// Self-checking bench for shift_table_loader: table-driven readback with a
// read scoreboard, plus hand-written load/error/reset sequences.
module tb_shift_table_loader;
  import cnn_shift_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              s_ready, busy, done, err, table_valid;
  logic [DATA_W-1:0] rd_data;
  logic [CSUM_W-1:0] checksum;

  int passCount = 0;
  int checkCount = 0;
  int doneCnt = 0;
  int errCnt = 0;

  logic [DATA_W-1:0] pattern [DEPTH];
  logic [CSUM_W-1:0] modelSum = '0;
  logic [DATA_W-1:0] expQ [$];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  shift_table_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .table_valid (table_valid),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) doneCnt++;
    if (err) errCnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [CSUM_W-1:0] expCsum();
`ifdef SHIFT_TABLE_CHECKSUM_EN
    return modelSum;
`else
    return '0;
`endif
  endfunction

  task automatic readAddr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    rd_addr = a;
    expQ.push_back(e);
    tick();
    checkOutput($sformatf("rd_data@%0d", a), {24'h0, rd_data}, {24'h0, expQ.pop_front()});
  endtask

  task automatic startLoad();
    modelSum = '0;
    doneCnt = 0;
    errCnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int lastAt, input int gapPct,
                               input int midStartAt, input bit probe);
    for (int i = 0; i < n; i++) begin
      if (gapPct > 0) begin
        for (int g = 0; g < 3 && $urandom_range(99) < gapPct; g++) begin
          s_valid = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = pattern[i];
      s_last  = (i == lastAt);
      start   = (i == midStartAt);
      if (probe) begin
        rd_addr = ADDR_W'(i);
        expQ.push_back('0);
      end
      checkOutput($sformatf("s_ready_byte%0d", i), {31'h0, s_ready}, 32'h1);
      tick();
      modelSum = modelSum + CSUM_W'(pattern[i]);
      start = 1'b0;
      if (probe) checkOutput($sformatf("rd_reload@%0d", i), {24'h0, rd_data}, {24'h0, expQ.pop_front()});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic checkFin(input string name, input bit expDone, input bit expErr, input bit expValid);
    checkOutput({name, "_done"}, {31'h0, done}, {31'h0, expDone});
    checkOutput({name, "_err"}, {31'h0, err}, {31'h0, expErr});
    checkOutput({name, "_valid"}, {31'h0, table_valid}, {31'h0, expValid});
    checkOutput({name, "_sready_fin"}, {31'h0, s_ready}, 32'h0);
    checkOutput({name, "_csum"}, {16'h0, checksum}, {16'h0, expCsum()});
    tick();
    tick();
    checkOutput({name, "_donecnt"}, doneCnt, {31'h0, expDone});
    checkOutput({name, "_errcnt"}, errCnt, {31'h0, expErr});
    checkOutput({name, "_csum_hold"}, {16'h0, checksum}, {16'h0, expCsum()});
    checkOutput({name, "_valid_hold"}, {31'h0, table_valid}, {31'h0, expValid});
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_sready"}, {31'h0, s_ready}, 32'h0);
    checkOutput({name, "_busy"}, {31'h0, busy}, 32'h0);
    checkOutput({name, "_done"}, {31'h0, done}, 32'h0);
    checkOutput({name, "_err"}, {31'h0, err}, 32'h0);
    checkOutput({name, "_valid"}, {31'h0, table_valid}, 32'h0);
    checkOutput({name, "_rddata"}, {24'h0, rd_data}, 32'h0);
    checkOutput({name, "_csum"}, {16'h0, checksum}, 32'h0);
  endtask

  initial begin
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Full load with index data, then table-driven readback.
    for (int i = 0; i < DEPTH; i++) pattern[i] = DATA_W'(i);
    startLoad();
    checkOutput("busy_load", {31'h0, busy}, 32'h1);
    applyStimulus(DEPTH, DEPTH - 1, 0, -1, 1'b0);
    checkFin("full", 1'b1, 1'b0, 1'b1);
`ifdef SHIFT_TABLE_CHECKSUM_EN
    checkOutput("full_csum_const", {16'h0, checksum}, 32'h1FC0);
`endif
    vecs[0] = '{7'd5,   8'h05};
    vecs[1] = '{7'd127, 8'h7F};
    vecs[2] = '{7'd0,   8'h00};
    vecs[3] = '{7'd64,  8'h40};
    vecs[4] = '{7'd1,   8'h01};
    vecs[5] = '{7'd126, 8'h7E};
    for (int v = 0; v < 6; v++) readAddr(vecs[v].addr, vecs[v].exp);

    // Signed values with random valid gaps.
    pattern[18] = 8'hFA;
    pattern[21] = 8'hE2;
    startLoad();
    applyStimulus(DEPTH, DEPTH - 1, 40, -1, 1'b0);
    checkFin("gaps", 1'b1, 1'b0, 1'b1);
    for (int a = 17; a <= 22; a++) readAddr(ADDR_W'(a), pattern[a]);
    readAddr(7'd127, 8'h7F);

    // start pulses mid-load must not rewind the pointer.
    for (int i = 0; i < DEPTH; i++) pattern[i] = ~DATA_W'(i);
    startLoad();
    applyStimulus(DEPTH, DEPTH - 1, 0, 50, 1'b0);
    checkFin("midstart", 1'b1, 1'b0, 1'b1);
    readAddr(7'd0, 8'hFF);
    readAddr(7'd60, ~8'd60);

    // Reload over a valid table: reads return zero until completion.
    for (int i = 0; i < DEPTH; i++) pattern[i] = DATA_W'(i * 3);
    startLoad();
    applyStimulus(DEPTH, DEPTH - 1, 0, -1, 1'b1);
    checkFin("reload", 1'b1, 1'b0, 1'b1);
    readAddr(7'd3, 8'd9);
    readAddr(7'd100, 8'(300));

    // Early last on byte 10.
    startLoad();
    applyStimulus(11, 10, 0, -1, 1'b0);
    checkFin("early", 1'b0, 1'b1, 1'b0);
    readAddr(7'd0, 8'h00);
    readAddr(7'd5, 8'h00);
    readAddr(7'd100, 8'h00);

    // Missing last: 128 bytes then a rejected 129th.
    for (int i = 0; i < DEPTH; i++) pattern[i] = DATA_W'(i + 1);
    startLoad();
    applyStimulus(DEPTH, -1, 0, -1, 1'b0);
    checkFin("nolast", 1'b0, 1'b1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("nolast_sready_%0d", c), {31'h0, s_ready}, 32'h0);
      tick();
    end
    s_valid = 1'b0;
    checkOutput("nolast_ram0", {24'h0, dut.u_ram.mem[0]}, 32'h1);
    checkOutput("nolast_ram127", {24'h0, dut.u_ram.mem[127]}, 32'h80);

    // Reset after 60 bytes, then a clean full load.
    for (int i = 0; i < DEPTH; i++) pattern[i] = DATA_W'(i);
    startLoad();
    applyStimulus(60, -1, 0, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midreset_idle_sready", {31'h0, s_ready}, 32'h0);
    startLoad();
    applyStimulus(DEPTH, DEPTH - 1, 0, -1, 1'b0);
    checkFin("afterreset", 1'b1, 1'b0, 1'b1);
    readAddr(7'd5, 8'h05);
    readAddr(7'd127, 8'h7F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
